// File: rtl/im_boot_loader.sv
// UART-driven program loader for the 16-bit instruction memory; owns the IM port while
// loading and passes CPU fetches through otherwise.
module im_boot_loader #(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 512,
  parameter int TIMEOUT = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
  localparam logic [15:0]   DEPTH16 = 16'(DEPTH);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       cnt;
  logic [7:0]        hi;
  logic [TW-1:0]     timer;
  logic [15:0]       len;

  assign len = {cnt[15:8], rx_data};

  // mem_we is part of busy so the write address stays on the IM port through the final write
  assign busy      = (state != IDLE) | mem_we;
  assign cpu_rst   = rst | busy;
  assign mem_addr  = busy ? wr_addr : cpu_addr;
  assign mem_rd_en = busy ? 1'b0 : cpu_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_addr   <= '0;
      cnt       <= '0;
      timer     <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (mem_we) wr_addr <= wr_addr + ADDR_W'(1);

      if (state == IDLE) begin
        if (load_req && !mem_we) begin
          state   <= LEN_HI;
          wr_addr <= '0;
          err     <= 1'b0;
          timer   <= '0;
        end
      end else if (rx_rdy) begin
        timer <= '0;
        case (state)
          LEN_HI: begin
            cnt[15:8] <= rx_data;
            state     <= LEN_LO;
          end
          LEN_LO: begin
            cnt[7:0] <= rx_data;
            if (len == 16'd0 || len > DEPTH16) begin
              state <= IDLE;
              err   <= 1'b1;
            end else begin
              state <= DAT_HI;
            end
          end
          DAT_HI: begin
            hi    <= rx_data;
            state <= DAT_LO;
          end
          DAT_LO: begin
            mem_wdata <= {hi, rx_data};
            mem_we    <= 1'b1;
            cnt       <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= DAT_HI;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timer == TMAX) begin
        state <= IDLE;
        err   <= 1'b1;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule
